// File: rtl/ip_arb_pkg.sv
// rtl/ip_arb_pkg.sv - shared types and constants for the ip update arbiter
//
// Purpose: source encoding for the resolved ip, output register state
// encoding and the default pointer width used by ip_update_arbiter and
// ip_arb_grant.
package ip_arb_pkg;

    localparam int IP_WIDTH_DEFAULT = 8;

    // Which requester produced the value currently held in ip.
    typedef enum logic [1:0] {
        IP_SRC_NONE   = 2'b00,
        IP_SRC_A      = 2'b01,
        IP_SRC_B      = 2'b10,
        IP_SRC_MERGED = 2'b11
    } ip_src_t;

    // One-entry output register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/ip_arb_grant.sv
// rtl/ip_arb_grant.sv - combinational winner selection between step and jump requests
//
// Purpose: decides which requester (if any) is granted this cycle.
// Ports:
//   a_valid_i/a_ip_i   step request and target
//   b_valid_i/b_ip_i   jump request and target
//   defer_cnt_i        consecutive cycles A has lost a conflict
//   can_load_i         output register can accept a new value this cycle
//   a_gnt_o/b_gnt_o    grants (both high on a merge)
//   src_o              source code of the granted value
module ip_arb_grant
    import ip_arb_pkg::*;
#(
    parameter int IP_WIDTH  = IP_WIDTH_DEFAULT,
    parameter int MAX_DEFER = 3,
    parameter int DEFER_W   = $clog2(MAX_DEFER + 1)
) (
    input  logic                a_valid_i,
    input  logic [IP_WIDTH-1:0] a_ip_i,
    input  logic                b_valid_i,
    input  logic [IP_WIDTH-1:0] b_ip_i,
    input  logic [DEFER_W-1:0]  defer_cnt_i,
    input  logic                can_load_i,
    output logic                a_gnt_o,
    output logic                b_gnt_o,
    output ip_src_t             src_o
);

    always_comb begin
        a_gnt_o = 1'b0;
        b_gnt_o = 1'b0;
        src_o   = IP_SRC_NONE;
        if (can_load_i) begin
            if (a_valid_i && b_valid_i) begin
                if (a_ip_i == b_ip_i) begin
                    // Same target: one write satisfies both requesters.
                    a_gnt_o = 1'b1;
                    b_gnt_o = 1'b1;
                    src_o   = IP_SRC_MERGED;
                end else if (defer_cnt_i == DEFER_W'(MAX_DEFER)) begin
                    // A has lost MAX_DEFER times in a row; let it through.
                    a_gnt_o = 1'b1;
                    src_o   = IP_SRC_A;
                end else begin
                    b_gnt_o = 1'b1;
                    src_o   = IP_SRC_B;
                end
            end else if (a_valid_i) begin
                a_gnt_o = 1'b1;
                src_o   = IP_SRC_A;
            end else if (b_valid_i) begin
                b_gnt_o = 1'b1;
                src_o   = IP_SRC_B;
            end
        end
    end

endmodule

// File: rtl/ip_update_arbiter.sv
// rtl/ip_update_arbiter.sv - merges step and jump ip updates into one ordered stream
//
// Purpose: arbitrates requester A (sequential step) against requester B
// (jump/branch) into a registered one-entry ip output. B wins conflicts,
// equal targets merge, and A is forced through after MAX_DEFER losses.
// Optional feature macro: IP_ARB_CONFLICT_COUNT_EN adds conflict_count.
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   a_valid/a_ip/a_ready    step request handshake
//   b_valid/b_ip/b_ready    jump request handshake
//   ip_valid/ip_ready/ip    resolved pointer handshake (ip registered)
//   ip_src                  source of ip: 00 none, 01 A, 10 B, 11 merged
//   conflict_count          saturating count of differing-target conflicts
module ip_update_arbiter
    import ip_arb_pkg::*;
#(
    parameter int IP_WIDTH  = IP_WIDTH_DEFAULT,
    parameter int MAX_DEFER = 3,
    parameter int RESET_IP  = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [IP_WIDTH-1:0] a_ip,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [IP_WIDTH-1:0] b_ip,
    output logic                b_ready,
    output logic                ip_valid,
    input  logic                ip_ready,
    output logic [IP_WIDTH-1:0] ip,
    output logic [1:0]          ip_src
`ifdef IP_ARB_CONFLICT_COUNT_EN
    ,
    output logic [15:0]         conflict_count
`endif
);

    localparam int DEFER_W = $clog2(MAX_DEFER + 1);

    out_state_t          state_q, state_d;
    logic [IP_WIDTH-1:0] ip_q, ip_d;
    ip_src_t             ip_src_q;
    logic [DEFER_W-1:0]  defer_cnt_q, defer_cnt_d;

    logic    can_load;
    logic    a_gnt, b_gnt, any_gnt;
    ip_src_t gnt_src;

    // Register is free when empty or when its value leaves this cycle.
    assign can_load = (state_q == OUT_EMPTY) || ip_ready;

    // Reset masks the grant so nothing is accepted while it is asserted.
    ip_arb_grant #(
        .IP_WIDTH  (IP_WIDTH),
        .MAX_DEFER (MAX_DEFER),
        .DEFER_W   (DEFER_W)
    ) u_grant (
        .a_valid_i   (a_valid),
        .a_ip_i      (a_ip),
        .b_valid_i   (b_valid),
        .b_ip_i      (b_ip),
        .defer_cnt_i (defer_cnt_q),
        .can_load_i  (can_load && !reset),
        .a_gnt_o     (a_gnt),
        .b_gnt_o     (b_gnt),
        .src_o       (gnt_src)
    );

    assign any_gnt = a_gnt || b_gnt;
    // On a merge both targets are equal, so taking b_ip covers it.
    assign ip_d    = b_gnt ? b_ip : a_ip;

    // Output state machine: state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output state machine: next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (any_gnt) state_d = OUT_FULL;
            OUT_FULL:  if (ip_ready) state_d = any_gnt ? OUT_FULL : OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    // Output state machine: outputs.
    always_comb begin
        ip_valid = (state_q == OUT_FULL);
        a_ready  = a_gnt;
        b_ready  = b_gnt;
    end

    // Starvation guard for A: counts consecutive lost cycles, frozen
    // while the output register is stalled.
    always_comb begin
        defer_cnt_d = defer_cnt_q;
        if (can_load) begin
            if (!a_valid || a_gnt) begin
                defer_cnt_d = '0;
            end else if (defer_cnt_q != DEFER_W'(MAX_DEFER)) begin
                defer_cnt_d = defer_cnt_q + DEFER_W'(1);
            end
        end
    end

    // ip and ip_src keep their last value when the register empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            ip_q        <= IP_WIDTH'(RESET_IP);
            ip_src_q    <= IP_SRC_NONE;
            defer_cnt_q <= '0;
        end else begin
            defer_cnt_q <= defer_cnt_d;
            if (any_gnt) begin
                ip_q     <= ip_d;
                ip_src_q <= gnt_src;
            end
        end
    end

    assign ip     = ip_q;
    assign ip_src = ip_src_q;

`ifdef IP_ARB_CONFLICT_COUNT_EN
    logic [15:0] conflict_q;

    // Counts differing-target collisions that reach arbitration; merges
    // are not conflicts.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (a_valid && b_valid && (a_ip != b_ip) && can_load
                     && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_ip_update_arbiter.sv
// tb/tb_ip_update_arbiter.sv - self-checking bench for ip_update_arbiter
module tb_ip_update_arbiter;

    localparam int W   = 8;
    localparam int MD  = 3;
    localparam int RIP = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         a_valid = 1'b0;
    logic [W-1:0] a_ip = '0;
    logic         a_ready;
    logic         b_valid = 1'b0;
    logic [W-1:0] b_ip = '0;
    logic         b_ready;
    logic         ip_valid;
    logic         ip_ready = 1'b0;
    logic [W-1:0] ip;
    logic [1:0]   ip_src;
`ifdef IP_ARB_CONFLICT_COUNT_EN
    logic [15:0]  conflict_count;
`endif

    ip_update_arbiter #(
        .IP_WIDTH  (W),
        .MAX_DEFER (MD),
        .RESET_IP  (RIP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ip     (a_ip),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_ip     (b_ip),
        .b_ready  (b_ready),
        .ip_valid (ip_valid),
        .ip_ready (ip_ready),
        .ip       (ip),
        .ip_src   (ip_src)
`ifdef IP_ARB_CONFLICT_COUNT_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the resolved stream as seen by the consumer.
    logic         m_valid;
    logic [W-1:0] m_ip;
    logic [1:0]   m_src;
    int           m_losses;
    int           m_conf;
    logic         e_a, e_b;

    task automatic cycle(input logic rst, input logic av, input logic [W-1:0] aip,
                         input logic bv, input logic [W-1:0] bip, input logic rdy);
        logic can, ga, gb;
        @(negedge clock);
        reset = rst; a_valid = av; a_ip = aip; b_valid = bv; b_ip = bip; ip_ready = rdy;
        #1;
        can = !m_valid || rdy;
        ga = 1'b0;
        gb = 1'b0;
        if (!rst && can) begin
            if (av && bv && aip == bip) begin
                ga = 1'b1; gb = 1'b1;
            end else if (av && bv) begin
                if (m_losses >= MD) ga = 1'b1; else gb = 1'b1;
            end else begin
                ga = av; gb = bv;
            end
        end
        check_eq("a_ready", a_ready, ga);
        check_eq("b_ready", b_ready, gb);
        e_a = ga;
        e_b = gb;
        if (rst) begin
            m_valid = 1'b0; m_ip = W'(RIP); m_src = 2'b00; m_losses = 0; m_conf = 0;
        end else if (can) begin
            if (av && bv && aip != bip && m_conf < 65535) m_conf++;
            if (ga || gb) begin
                m_valid = 1'b1;
                m_ip    = gb ? bip : aip;
                m_src   = {gb, ga};
            end else begin
                m_valid = 1'b0;
            end
            if (av && !ga) m_losses = (m_losses < MD) ? m_losses + 1 : MD;
            else           m_losses = 0;
        end
        @(posedge clock);
        #1;
        check_eq("ip_valid", ip_valid, m_valid);
        check_eq("ip", ip, m_ip);
        check_eq("ip_src", ip_src, m_src);
`ifdef IP_ARB_CONFLICT_COUNT_EN
        check_eq("conflict_count", conflict_count, m_conf);
`endif
    endtask

    logic         ap, bp, rr, rs;
    logic [W-1:0] at, bt;

    initial begin
        // Reset with idle inputs, then with A requesting during reset.
        cycle(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        check_eq("rst_ip", ip, RIP);
        check_eq("rst_valid", ip_valid, 0);
        cycle(1'b1, 1'b1, 8'd7, 1'b0, 8'd0, 1'b1);
        check_eq("rst_hold_a_ready_ip", ip, RIP);

        // A only.
        cycle(1'b0, 1'b1, 8'd1, 1'b0, 8'd0, 1'b1);
        check_eq("a_only_ip", ip, 1);
        check_eq("a_only_src", ip_src, 2'b01);

        // Merge of equal targets.
        cycle(1'b0, 1'b1, 8'd2, 1'b1, 8'd2, 1'b1);
        check_eq("merge_src", ip_src, 2'b11);
        check_eq("merge_ip", ip, 2);

        // Sustained conflict: B three times, then A forced through.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 8'd1, 1'b1, 8'd3, 1'b1);
            check_eq("starve_ip", ip, (k < 3) ? 3 : 1);
            check_eq("starve_src", ip_src, (k < 3) ? 2'b10 : 2'b01);
`ifdef IP_ARB_CONFLICT_COUNT_EN
            check_eq("starve_conflicts", conflict_count, k + 1);
`endif
        end

        // Downstream stall with B pending.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 1'b0);
            check_eq("stall_ip", ip, 1);
            check_eq("stall_b_ready", b_ready, 0);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 1'b1);
        check_eq("unstall_ip", ip, 9);
        check_eq("unstall_valid", ip_valid, 1);

        // Reset while full and stalled, with A deferred once.
        cycle(1'b0, 1'b1, 8'd1, 1'b1, 8'd3, 1'b1);
        cycle(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        check_eq("pre_rst_defer", dut.defer_cnt_q, 1);
        cycle(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        check_eq("mid_rst_valid", ip_valid, 0);
        check_eq("mid_rst_ip", ip, RIP);
        check_eq("mid_rst_defer", dut.defer_cnt_q, 0);

        // Randomized traffic; requesters hold until accepted.
        ap = 1'b0; bp = 1'b0; at = '0; bt = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!ap && ($urandom % 3 != 0)) begin ap = 1'b1; at = W'($urandom_range(0, 3)); end
            if (!bp && ($urandom % 3 != 0)) begin bp = 1'b1; bt = W'($urandom_range(0, 3)); end
            rs = ($urandom % 150 == 0);
            rr = ($urandom % 4 != 0);
            cycle(rs, ap, at, bp, bt, rr);
            if (e_a) ap = 1'b0;
            if (e_b) bp = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
